pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. Generates per-latch write-enable and flush for IF/ID, ID/EX, EX/MEM and MEM/WB, plus PC enable, from cache hits, load-use detection, taken branches, jumps and halt. Owns the halt-drain state machine and a stall-cycle performance counter. Sits beside the datapath; its outputs drive the writeEN/flush inputs of every pipeline latch.

Parameters:
CNT_W, 32, width of stall_cnt.
LU_EN, 1, 1 = load-use stall detection active; 0 = detection disabled, luse forced 0.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  asynchronous active-low reset.
ihit  input  1  instruction fetch completed this cycle.
dhit  input  1  data access completed this cycle.
dmemREN  input  1  MEM-stage instruction reads memory.
dmemWEN  input  1  MEM-stage instruction writes memory.
idex_MemToReg  input  1  EX-stage instruction is a load.
idex_writeReg  input  5  EX-stage destination register.
ifid_rs  input  5  ID-stage rs.
ifid_rt  input  5  ID-stage rt.
branch_taken  input  1  MEM-stage branch/JR resolved taken.
jump_id  input  1  ID-stage J/JAL.
halt_mem  input  1  MEM-stage instruction is HALT.
pc_en  output  1  PC update enable.
ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch write enables.
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  latch clear (overrides en).
halt_out  output  1  processor halted, sticky.
state  output  2  RUN=0, DWAIT=1, DRAIN=2, HALTED=3.
stall_cnt  output  CNT_W  count of cycles with pc_en=0 in RUN/DWAIT.

Behaviour:
- Reset (nRST=0, async): state=RUN, halt_out=0, stall_cnt=0; all en and flush outputs 0 while nRST=0.
- Signals: dreq = dmemREN|dmemWEN; dstall = dreq & ~dhit; luse = LU_EN & idex_MemToReg & (idex_writeReg!=0) & (idex_writeReg==ifid_rs | idex_writeReg==ifid_rt).
- Enables/flushes are combinational from state and inputs; state, halt_out, stall_cnt are registered.
- Default (RUN, no event): all en=1, all flush=0.
- RUN priority, highest first:
  1 dstall: pc/ifid/idex/exmem en=0; memwb_flush=1. Next state DWAIT.
  2 halt_mem: pc_en=0; ifid/idex/exmem flush=1; memwb_en=1. Next DRAIN.
  3 branch_taken: ifid/idex/exmem flush=1; pc_en=1; memwb_en=1.
  4 luse: pc_en=0, ifid_en=0, idex_flush=1; exmem/memwb en=1. If also ~ihit, same outputs.
  5 jump_id: ifid_flush=1, pc_en=ihit; others en=1.
  6 ~ihit: pc_en=0, ifid_flush=1; others en=1.
- DWAIT: same outputs as RUN case 1 while ~dhit. On dhit, outputs are those RUN would produce with dstall=0 this cycle and next state RUN.
- DRAIN: one cycle; pc_en=0; ifid/idex/exmem flush=1; memwb_en=1 (HALT reaches WB). Next HALTED.
- HALTED: all en=0, flush=0; halt_out=1; remains until reset. All inputs ignored.
- stall_cnt increments when state in {RUN, DWAIT} and pc_en=0; saturates at all-ones.
- Reset mid-DWAIT/DRAIN returns to RUN immediately with no residual stall.
- A flushed latch is cleared even if its en=0.

Test Plan:
- Reset then ihit=1, no hazards for 5 cycles -> all en=1, flushes 0, state=0, stall_cnt=0.
- dmemREN=1, dhit=0 for 3 cycles then dhit=1 -> state 0->1 for 3 cycles, pc/ifid/idex/exmem en=0, memwb_flush=1; on hit cycle all en=1, state returns 0; stall_cnt=3.
- idex_MemToReg=1, idex_writeReg=8, ifid_rt=8 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; with idex_writeReg=0 -> no stall.
- branch_taken=1 together with luse=1 -> ifid/idex/exmem flush=1, pc_en=1 (branch wins).
- halt_mem=1 -> cycle 1 state=2, memwb_en=1; cycle 2 state=3, halt_out=1, all en=0; further ihit/branch inputs ignored until nRST low.
- nRST asserted asynchronously during DWAIT -> state=0, stall_cnt=0, halt_out=0 without waiting for a CLK edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage MIPS pipeline.
// Produces PC enable plus write-enable/flush for every pipeline latch from
// cache handshakes and hazard indicators, runs the halt-drain FSM and keeps
// a saturating count of stalled cycles.
module pipe_ctrl #(
  parameter int CNT_W = 32,
  parameter bit LU_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic             idex_MemToReg,
  input  logic [4:0]       idex_writeReg,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt_out,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DWAIT  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0] state_next;
  logic       dreq;
  logic       dstall;
  logic       luse;
  logic       mem_hold;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}})
      return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Hazard decode shared by the next-state and output logic.
  always_comb begin
    dreq   = dmemREN | dmemWEN;
    dstall = dreq & ~dhit;
    luse   = LU_EN && idex_MemToReg && (idex_writeReg != 5'd0) &&
             ((idex_writeReg == ifid_rs) || (idex_writeReg == ifid_rt));
    // In RUN a miss starts the data stall; in DWAIT we keep holding until dhit.
    mem_hold = 1'b0;
    if (state == RUN)
      mem_hold = dstall;
    else if (state == DWAIT)
      mem_hold = ~dhit;
  end

  // State register with sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      halt_out <= 1'b0;
    end else begin
      state    <= state_next;
      halt_out <= halt_out | (state_next == HALTED);
    end
  end

  // Next-state logic for the run / data-wait / drain / halted sequence.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (dstall)
          state_next = DWAIT;
        else if (halt_mem)
          state_next = DRAIN;
      end
      DWAIT:   if (dhit) state_next = RUN;
      DRAIN:   state_next = HALTED;
      default: state_next = HALTED;
    endcase
  end

  // Latch enable/flush decode; RUN priorities also serve DWAIT on the hit cycle.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (state)
      RUN, DWAIT: begin
        if (mem_hold) begin
          // Freeze everything upstream of MEM; bubble into WB.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else if (state == RUN && halt_mem) begin
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (luse) begin
          // Hold the dependent instruction in ID, inject a bubble into EX.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (jump_id) begin
          pc_en      = ihit;
          ifid_flush = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        // Let HALT retire into WB while squashing everything behind it.
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      default: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
    endcase
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  // Stall-cycle performance counter, only live while the pipe is running.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if ((state == RUN || state == DWAIT) && !pc_en)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with a small counter width
// so counter saturation is reachable in a short run.
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dhit, dmemREN, dmemWEN, idex_MemToReg;
  logic [4:0]    idex_writeReg, ifid_rs, ifid_rt;
  logic          branch_taken, jump_id, halt_mem;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic          halt_out;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0]    m_state;
  logic [CW-1:0] m_cnt;
  logic          m_halt;
  logic [8:0]    sb[$];

  pipe_ctrl #(.CNT_W(CW), .LU_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .idex_MemToReg(idex_MemToReg), .idex_writeReg(idex_writeReg),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .jump_id(jump_id), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt_out(halt_out), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
  function automatic logic [8:0] model_out(input logic [1:0] st);
    logic dstall_m, lu;
    dstall_m = (dmemREN | dmemWEN) & ~dhit;
    lu = idex_MemToReg && (idex_writeReg != 5'd0) &&
         (idex_writeReg == ifid_rs || idex_writeReg == ifid_rt);
    if (!nRST) return 9'b0_0000_0000;
    if (st == 2'd3) return 9'b0_0000_0000;
    if (st == 2'd2) return 9'b0_1111_1110;
    if (st == 2'd1 && !dhit) return 9'b0_0001_0001;
    if (st == 2'd0 && dstall_m) return 9'b0_0001_0001;
    if (st == 2'd0 && halt_mem) return 9'b0_1111_1110;
    if (branch_taken) return 9'b1_1111_1110;
    if (lu) return 9'b0_0111_0100;
    if (jump_id) return {ihit, 8'b1111_1000};
    if (!ihit) return 9'b0_1111_1000;
    return 9'b1_1111_0000;
  endfunction

  function automatic logic [8:0] dut_out();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush};
  endfunction

  // One clock: called at a falling edge with inputs already applied.
  task automatic cycle(input string tag);
    logic [8:0]    e;
    logic [1:0]    ns;
    logic [CW-1:0] nc;
    logic          nh;
    #1 sb.push_back(model_out(m_state));
    #1;
    e = sb.pop_front();
    check_val({tag, ".outs"}, 64'(dut_out()), 64'(e));
    ns = m_state; nc = m_cnt; nh = m_halt;
    if (!nRST) begin
      ns = 2'd0; nc = '0; nh = 1'b0;
    end else begin
      case (m_state)
        2'd0: ns = ((dmemREN | dmemWEN) & ~dhit) ? 2'd1 : (halt_mem ? 2'd2 : 2'd0);
        2'd1: ns = dhit ? 2'd0 : 2'd1;
        default: ns = 2'd3;
      endcase
      if (m_state <= 2'd1 && !e[8] && m_cnt != {CW{1'b1}}) nc = m_cnt + 1'b1;
      if (ns == 2'd3) nh = 1'b1;
    end
    @(posedge CLK);
    #1;
    m_state = ns; m_cnt = nc; m_halt = nh;
    check_val({tag, ".state"}, 64'(state), 64'(m_state));
    check_val({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    check_val({tag, ".halt_out"}, 64'(halt_out), 64'(m_halt));
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    idex_MemToReg = 1'b0; idex_writeReg = 5'd0; ifid_rs = 5'd1; ifid_rt = 5'd2;
    branch_taken = 1'b0; jump_id = 1'b0; halt_mem = 1'b0;
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    m_state = 2'd0; m_cnt = '0; m_halt = 1'b0;
    @(negedge CLK);
    cycle("reset");
    cycle("reset2");
    nRST = 1'b1;

    for (int i = 0; i < 5; i++) cycle("idle");

    // Data miss for three cycles, then hit
    dmemREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) cycle("dmiss");
    dhit = 1'b1;
    cycle("dhit");
    check_val("dstall_total", 64'(stall_cnt), 64'd3);
    idle_inputs();

    // Load-use on rt, then same load to $0
    idex_MemToReg = 1'b1; idex_writeReg = 5'd8; ifid_rt = 5'd8;
    cycle("luse_rt");
    ihit = 1'b0;
    cycle("luse_nohit");
    ihit = 1'b1; ifid_rs = 5'd8; ifid_rt = 5'd3;
    cycle("luse_rs");
    idex_writeReg = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    cycle("luse_r0");

    // Branch beats load-use
    idex_writeReg = 5'd9; ifid_rs = 5'd9; branch_taken = 1'b1;
    cycle("br_luse");
    idle_inputs();

    // Jump with and without fetch hit, plain fetch miss
    jump_id = 1'b1;
    cycle("jump_hit");
    ihit = 1'b0;
    cycle("jump_miss");
    jump_id = 1'b0;
    cycle("imiss");
    idle_inputs();

    // Long load-use stall drives the counter into saturation
    idex_MemToReg = 1'b1; idex_writeReg = 5'd4; ifid_rs = 5'd4;
    for (int i = 0; i < 20; i++) cycle("luse_sat");
    check_val("cnt_sat", 64'(stall_cnt), 64'(4'hF));
    idle_inputs();

    // Asynchronous reset in the middle of a data wait
    dmemWEN = 1'b1; dhit = 1'b0;
    cycle("dwait_a");
    cycle("dwait_b");
    #2 nRST = 1'b0;
    #1;
    check_val("async_state", 64'(state), 64'd0);
    check_val("async_cnt", 64'(stall_cnt), 64'd0);
    check_val("async_halt", 64'(halt_out), 64'd0);
    check_val("async_outs", 64'(dut_out()), 64'd0);
    m_state = 2'd0; m_cnt = '0; m_halt = 1'b0;
    @(negedge CLK);
    cycle("in_reset");
    idle_inputs();
    nRST = 1'b1;
    cycle("post_reset");

    // Halt: drain one cycle, then halted with inputs ignored
    halt_mem = 1'b1;
    cycle("halt_run");
    halt_mem = 1'b0;
    cycle("drain");
    branch_taken = 1'b1; dmemREN = 1'b1; ihit = 1'b1;
    for (int i = 0; i < 3; i++) cycle("halted");
    idle_inputs();
    nRST = 1'b0;
    cycle("halt_reset");
    nRST = 1'b1;
    cycle("after_halt");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got no end, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
